// File: rtl/dcache_line_adapter.sv
// Whole-line dcache DFP requests turned into 4-beat bursts on the banked memory port.
// Optional read-return address checking: define DCACHE_ADAPTER_ADDR_CHECK_EN.
module dcache_line_adapter #(
   parameter int unsigned ADDR_BITS = 32,
   parameter int unsigned LINE_BITS = 256,
   parameter int unsigned BEAT_BITS = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [ADDR_BITS-1:0] dfp_addr,
   input  logic                 dfp_read,
   input  logic                 dfp_write,
   input  logic [LINE_BITS-1:0] dfp_wdata,
   output logic [LINE_BITS-1:0] dfp_rdata,
   output logic                 dfp_resp,
   output logic [ADDR_BITS-1:0] bmem_addr,
   output logic                 bmem_read,
   output logic                 bmem_write,
   output logic [BEAT_BITS-1:0] bmem_wdata,
   input  logic                 bmem_ready,
   input  logic [ADDR_BITS-1:0] bmem_raddr,
   input  logic [BEAT_BITS-1:0] bmem_rdata,
   input  logic                 bmem_rvalid,
   output logic                 addr_err
);

   localparam int unsigned BEATS    = LINE_BITS / BEAT_BITS;
   localparam int unsigned OFFSET   = $clog2(LINE_BITS / 8);
   localparam int unsigned CNT_BITS = $clog2(BEATS);
   localparam logic [CNT_BITS-1:0]  LAST_BEAT = CNT_BITS'(BEATS - 1);
   localparam logic [ADDR_BITS-1:0] LINE_MASK = ~ADDR_BITS'((64'd1 << OFFSET) - 64'd1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_BEAT,
      S_WR_BEAT,
      S_RESP
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [CNT_BITS-1:0]   r_cnt;
   logic [ADDR_BITS-1:0]  r_line_addr;
   logic [LINE_BITS-1:0]  r_wline;
   logic [LINE_BITS-1:0]  r_rdata;
   logic [BEAT_BITS-1:0]  w_wbeat;
   logic                  w_rd_beat;
   logic                  w_wr_beat;

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // Outgoing write beat selected by the beat counter
   always_comb begin
      w_wbeat = '0;
      for (int unsigned b = 0; b < BEATS; b++) begin
         if (r_cnt == CNT_BITS'(b)) w_wbeat = r_wline[b*BEAT_BITS +: BEAT_BITS];
      end
   end

   always_comb begin
      w_next     = r_state;
      dfp_resp   = 1'b0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
      w_rd_beat  = 1'b0;
      w_wr_beat  = 1'b0;
      case (r_state)
         S_IDLE: begin
            // Write wins so a dirty victim lands before the refill fetch
            if (dfp_write)     w_next = S_WR_BEAT;
            else if (dfp_read) w_next = S_RD_REQ;
         end
         S_RD_REQ: begin
            bmem_read = 1'b1;
            if (bmem_ready) w_next = S_RD_BEAT;
         end
         S_RD_BEAT: begin
            w_rd_beat = bmem_rvalid;
            if (bmem_rvalid && (r_cnt == LAST_BEAT)) w_next = S_RESP;
         end
         S_WR_BEAT: begin
            bmem_write = 1'b1;
            bmem_wdata = w_wbeat;
            w_wr_beat  = bmem_ready;
            if (bmem_ready && (r_cnt == LAST_BEAT)) w_next = S_RESP;
         end
         S_RESP: begin
            dfp_resp = 1'b1;
            w_next   = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt       <= '0;
         r_line_addr <= '0;
         r_wline     <= '0;
         r_rdata     <= '0;
      end else begin
         if (r_state == S_IDLE) begin
            r_cnt <= '0;
            if (dfp_write) begin
               r_line_addr <= dfp_addr & LINE_MASK;
               r_wline     <= dfp_wdata;
            end else if (dfp_read) begin
               r_line_addr <= dfp_addr & LINE_MASK;
            end
         end
         if (w_rd_beat || w_wr_beat) r_cnt <= r_cnt + CNT_BITS'(1);
         // Returned beat lands in the slice named by the counter
         if (w_rd_beat) begin
            for (int unsigned b = 0; b < BEATS; b++) begin
               if (r_cnt == CNT_BITS'(b)) r_rdata[b*BEAT_BITS +: BEAT_BITS] <= bmem_rdata;
            end
         end
      end
   end

   assign bmem_addr = r_line_addr;
   assign dfp_rdata = r_rdata;

`ifdef DCACHE_ADAPTER_ADDR_CHECK_EN
   logic r_addr_err;

   // Sticky until reset; the mismatching beat is still stored
   always_ff @(posedge clk) begin
      if (rst)                                         r_addr_err <= 1'b0;
      else if (w_rd_beat && (bmem_raddr != r_line_addr)) r_addr_err <= 1'b1;
   end

   assign addr_err = r_addr_err;
`else
   logic w_unused_raddr;

   assign w_unused_raddr = ^bmem_raddr;
   assign addr_err       = 1'b0;
`endif

endmodule

// File: tb/tb_dcache_line_adapter.sv
// Table-driven cycle-by-cycle check of dcache_line_adapter: read, stalled write,
// writeback-then-fetch, mid-burst reset, stray beats and the address check.
module tb_dcache_line_adapter;

   localparam logic N = 1'b0;
   localparam logic Y = 1'b1;
`ifdef DCACHE_ADAPTER_ADDR_CHECK_EN
   localparam logic E = 1'b1;
`else
   localparam logic E = 1'b0;
`endif

   localparam logic [31:0]  Z32  = 32'h0;
   localparam logic [63:0]  Z64  = 64'h0;
   localparam logic [255:0] Z256 = 256'h0;

   localparam logic [63:0] BA = {16{4'hA}}, BB = {16{4'hB}}, BC = {16{4'hC}}, BD = {16{4'hD}};
   localparam logic [63:0] B11 = {8{8'h11}}, B22 = {8{8'h22}}, B33 = {8{8'h33}}, B44 = {8{8'h44}};
   localparam logic [63:0] B01 = {8{8'h01}}, B02 = {8{8'h02}}, B03 = {8{8'h03}}, B04 = {8{8'h04}};
   localparam logic [63:0] B55 = {8{8'h55}}, B66 = {8{8'h66}}, B77 = {8{8'h77}}, B99 = {8{8'h99}};
   localparam logic [63:0] B81 = {8{8'h81}}, B82 = {8{8'h82}}, B83 = {8{8'h83}}, B84 = {8{8'h84}};
   localparam logic [63:0] BA1 = {8{8'hA1}}, BA2 = {8{8'hA2}}, BA3 = {8{8'hA3}}, BA4 = {8{8'hA4}};

   localparam logic [255:0] LW = {BD, BC, BB, BA};
   localparam logic [255:0] L1 = {B44, B33, B22, B11};
   localparam logic [255:0] L2 = {B04, B03, B02, B01};
   localparam logic [255:0] L3 = {B84, B83, B82, B81};
   localparam logic [255:0] L4 = {BA4, BA3, BA2, BA1};

   localparam logic [31:0] RA = 32'h1000_0034, LA1 = 32'h1000_0020;
   localparam logic [31:0] WADR = 32'h3000_005F, WA = 32'h3000_0040;
   localparam logic [31:0] SA = 32'h4000_0000;
   localparam logic [31:0] FADR = 32'h5000_0010, FA = 32'h5000_0000;
   localparam logic [31:0] R6 = 32'h6000_0008, A6 = 32'h6000_0000;
   localparam logic [31:0] R7 = 32'h7000_0020;
   localparam logic [31:0] BAD = 32'h2000_0000;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  dfp_addr;
   logic         dfp_read, dfp_write;
   logic [255:0] dfp_wdata;
   logic [255:0] dfp_rdata;
   logic         dfp_resp;
   logic [31:0]  bmem_addr;
   logic         bmem_read, bmem_write;
   logic [63:0]  bmem_wdata;
   logic         bmem_ready;
   logic [31:0]  bmem_raddr;
   logic [63:0]  bmem_rdata;
   logic         bmem_rvalid;
   logic         addr_err;

   dcache_line_adapter dut (
      .clk(clk), .rst(rst),
      .dfp_addr(dfp_addr), .dfp_read(dfp_read), .dfp_write(dfp_write),
      .dfp_wdata(dfp_wdata), .dfp_rdata(dfp_rdata), .dfp_resp(dfp_resp),
      .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write),
      .bmem_wdata(bmem_wdata), .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr),
      .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic rst, rd, wr; logic [31:0] a; logic rdy, rv; logic [63:0] rdat; logic [31:0] radr;
      logic e_resp, e_rd, e_wr; logic c_a; logic [31:0] e_a; logic c_wd; logic [63:0] e_wd;
      logic c_l; logic [255:0] e_l; logic e_err;
   } vec_t;

   vec_t vecs[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   function automatic vec_t V(logic rst_i, logic rd, logic wr, logic [31:0] a, logic rdy, logic rv,
                              logic [63:0] rdat, logic [31:0] radr, logic e_resp, logic e_rd,
                              logic e_wr, logic c_a, logic [31:0] e_a, logic c_wd, logic [63:0] e_wd,
                              logic c_l, logic [255:0] e_l, logic e_err);
      vec_t v;
      v.rst = rst_i; v.rd = rd; v.wr = wr; v.a = a; v.rdy = rdy; v.rv = rv; v.rdat = rdat;
      v.radr = radr; v.e_resp = e_resp; v.e_rd = e_rd; v.e_wr = e_wr; v.c_a = c_a; v.e_a = e_a;
      v.c_wd = c_wd; v.e_wd = e_wd; v.c_l = c_l; v.e_l = e_l; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string nm, input int i, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL vec %0d %s: got %h expected %h", i, nm, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, Y,Z32, Y,Z64, Y,Z256, N));
      // Read, ready on first request cycle, beats back to back
      vecs.push_back(V(N,Y,N,RA, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, Y,N,Z64,Z32, N,Y,N, Y,LA1, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,B11,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,B22,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,B33,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,B44,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, Y,L1, N));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L1, N));
      // Write with two low-ready cycles on the second beat
      vecs.push_back(V(N,N,Y,WADR, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L1, N));
      vecs.push_back(V(N,N,Y,WADR, Y,N,Z64,Z32, N,N,Y, Y,WA, Y,BA, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, N,N,Z64,Z32, N,N,Y, Y,WA, Y,BB, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, N,N,Z64,Z32, N,N,Y, Y,WA, Y,BB, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, Y,N,Z64,Z32, N,N,Y, Y,WA, Y,BB, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, Y,N,Z64,Z32, N,N,Y, Y,WA, Y,BC, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, Y,N,Z64,Z32, N,N,Y, Y,WA, Y,BD, N,Z256, N));
      vecs.push_back(V(N,N,Y,WADR, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L1, N));
      // Simultaneous read+write: write first, then fetch two cycles after its resp
      vecs.push_back(V(N,Y,Y,SA, Y,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,Y,SA, Y,N,Z64,Z32, N,N,Y, Y,SA, Y,BA, N,Z256, N));
      vecs.push_back(V(N,Y,Y,SA, Y,N,Z64,Z32, N,N,Y, Y,SA, Y,BB, N,Z256, N));
      vecs.push_back(V(N,Y,Y,SA, Y,N,Z64,Z32, N,N,Y, Y,SA, Y,BC, N,Z256, N));
      vecs.push_back(V(N,Y,Y,SA, Y,N,Z64,Z32, N,N,Y, Y,SA, Y,BD, N,Z256, N));
      vecs.push_back(V(N,Y,Y,SA, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, Y,N,Z64,Z32, N,Y,N, Y,FA, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,Y,B01,FA, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,Y,B02,FA, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,Y,B03,FA, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,Y,B04,FA, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,FADR, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, Y,L2, N));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L2, N));
      // Reset after the second read beat, stray beats in IDLE, then a stalled read
      vecs.push_back(V(N,Y,N,R6, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R6, Y,N,Z64,Z32, N,Y,N, Y,A6, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R6, N,Y,B55,A6, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R6, N,Y,B66,A6, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(Y,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,N,N,Z32, N,Y,B77,Z32, N,N,N, Y,Z32, Y,Z64, Y,Z256, N));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,N,Z64,Z32, N,Y,N, Y,R7, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, Y,N,Z64,Z32, N,Y,N, Y,R7, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,Y,B81,R7, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,Y,B82,R7, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,Y,B83,R7, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,Y,B84,R7, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,R7, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, Y,L3, N));
      vecs.push_back(V(N,N,N,Z32, N,Y,B99,Z32, N,N,N, N,Z32, N,Z64, Y,L3, N));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L3, N));
      // Third beat returns a foreign address tag
      vecs.push_back(V(N,Y,N,RA, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, Y,N,Z64,Z32, N,Y,N, Y,LA1, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,BA1,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,BA2,LA1, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,BA3,BAD, N,N,N, N,Z32, N,Z64, N,Z256, N));
      vecs.push_back(V(N,Y,N,RA, N,Y,BA4,LA1, N,N,N, N,Z32, N,Z64, N,Z256, E));
      vecs.push_back(V(N,Y,N,RA, N,N,Z64,Z32, Y,N,N, N,Z32, N,Z64, Y,L4, E));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L4, E));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, Y,L4, E));
      vecs.push_back(V(Y,N,N,Z32, N,N,Z64,Z32, N,N,N, N,Z32, N,Z64, N,Z256, E));
      vecs.push_back(V(N,N,N,Z32, N,N,Z64,Z32, N,N,N, Y,Z32, Y,Z64, Y,Z256, N));

      rst = 1'b1; dfp_addr = Z32; dfp_read = N; dfp_write = N; dfp_wdata = LW;
      bmem_ready = N; bmem_raddr = Z32; bmem_rdata = Z64; bmem_rvalid = N;
      repeat (2) @(posedge clk);
      #1;

      for (int i = 0; i < vecs.size(); i++) begin
         rst         = vecs[i].rst;
         dfp_read    = vecs[i].rd;
         dfp_write   = vecs[i].wr;
         dfp_addr    = vecs[i].a;
         bmem_ready  = vecs[i].rdy;
         bmem_rvalid = vecs[i].rv;
         bmem_rdata  = vecs[i].rdat;
         bmem_raddr  = vecs[i].radr;
         @(negedge clk);
         chk("dfp_resp",   i, 256'(dfp_resp),   256'(vecs[i].e_resp));
         chk("bmem_read",  i, 256'(bmem_read),  256'(vecs[i].e_rd));
         chk("bmem_write", i, 256'(bmem_write), 256'(vecs[i].e_wr));
         chk("addr_err",   i, 256'(addr_err),   256'(vecs[i].e_err));
         if (vecs[i].c_a)  chk("bmem_addr",  i, 256'(bmem_addr),  256'(vecs[i].e_a));
         if (vecs[i].c_wd) chk("bmem_wdata", i, 256'(bmem_wdata), 256'(vecs[i].e_wd));
         if (vecs[i].c_l)  chk("dfp_rdata",  i, dfp_rdata,        vecs[i].e_l);
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
